beta_exe_wb_stage: RTL

BETA_EXE_WB_STAGE -- requirements
Module: beta_exe_wb_stage

---
 rtl/beta_exe_wb_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/beta_exe_wb_stage.sv
// Two-entry execute-to-writeback buffer: formats ALU results at push and presents them in FIFO order.
// Optional build macro BETA_EXE_WB_PERF_EN adds a saturating 32-bit writeback stall counter.
package beta_pkg;
  parameter int XLEN = 32;
endpackage

module beta_exe_wb_stage #(
  parameter int XLEN  = beta_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            alu_op_end_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  input  logic            alu_negative_i,
  input  logic [1:0]      res_sel_i,
  input  logic [2:0]      branch_cond_i,
  input  logic [4:0]      rd_addr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_we_o,
  output logic            branch_taken_o
`ifdef BETA_EXE_WB_PERF_EN
  ,
  output logic [31:0]     stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e            state_r, state_next_s;
  logic            head_r, tail_r;
  logic [XLEN-1:0] data_r  [DEPTH];
  logic [4:0]      rd_r    [DEPTH];
  logic            br_r    [DEPTH];
  logic            taken_r [DEPTH];
  logic            push_s, pop_s;
  logic [XLEN-1:0] fmt_data_s;
  logic            fmt_br_s, fmt_taken_s;

  function automatic logic branch_eval(input logic [2:0] cond, input logic zero, input logic neg);
    case (cond)
      3'b000:         branch_eval = zero;
      3'b001:         branch_eval = ~zero;
      3'b100, 3'b110: branch_eval = neg;
      3'b101, 3'b111: branch_eval = ~neg;
      default:        branch_eval = 1'b0;
    endcase
  endfunction

  // Handshake decode from occupancy; there is no bypass from input to output.
  always_comb begin
    in_ready_o  = (state_r != FULL);
    out_valid_o = (state_r == ONE) || (state_r == FULL);
    push_s      = in_valid_i & alu_op_end_i & in_ready_o & ~flush_i;
    pop_s       = out_valid_o & out_ready_i & ~flush_i;
  end

  // Entry formatting applied at push time.
  always_comb begin
    fmt_data_s  = alu_result_i;
    fmt_br_s    = (res_sel_i == 2'b10);
    fmt_taken_s = 1'b0;
    if (res_sel_i == 2'b01) begin
      fmt_data_s = {{(XLEN-1){1'b0}}, alu_negative_i};
    end else begin
      fmt_data_s = alu_result_i;
    end
    if (fmt_br_s) begin
      fmt_taken_s = branch_eval(branch_cond_i, alu_zero_i, alu_negative_i);
    end else begin
      fmt_taken_s = 1'b0;
    end
  end

  // Occupancy next-state logic; flush overrides push and pop.
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY:   state_next_s = push_s ? ONE : EMPTY;
        ONE: begin
          if (push_s && !pop_s) begin
            state_next_s = FULL;
          end else if (pop_s && !push_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        FULL:    state_next_s = pop_s ? ONE : FULL;
        default: state_next_s = EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pointers and entry storage; flush rewinds both pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_r <= 1'b0;
      tail_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i]  <= '0;
        rd_r[i]    <= 5'd0;
        br_r[i]    <= 1'b0;
        taken_r[i] <= 1'b0;
      end
    end else if (flush_i) begin
      head_r <= 1'b0;
      tail_r <= 1'b0;
    end else begin
      if (push_s) begin
        data_r[tail_r]  <= fmt_data_s;
        rd_r[tail_r]    <= rd_addr_i;
        br_r[tail_r]    <= fmt_br_s;
        taken_r[tail_r] <= fmt_taken_s;
        tail_r          <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
    end
  end

  // Head-entry fields driven straight from storage.
  always_comb begin
    wb_data_o      = data_r[head_r];
    wb_rd_o        = rd_r[head_r];
    branch_taken_o = taken_r[head_r];
    wb_we_o        = out_valid_o & (rd_r[head_r] != 5'd0) & ~br_r[head_r];
  end

`ifdef BETA_EXE_WB_PERF_EN
  // Saturating count of cycles where the head entry is blocked by writeback.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= 32'd0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end else begin
      stall_cnt_o <= stall_cnt_o;
    end
  end
`else
  // Base build carries no stall counter.
`endif

endmodule
